dot_acc_engine: RTL and testbench



---
 rtl/dot_acc_pkg.sv | 24 ++
 rtl/dot_sum_tree.sv | 31 +++
 rtl/dot_acc_engine.sv | 160 ++++++++++++++++
 tb/tb_dot_acc_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Shared widths, the partial-sum width helper and the S2 stage record for dot_acc_engine.
// The optional saturating accumulator is enabled with DOT_ACC_SAT_EN.
package dot_acc_pkg;

  localparam int DEF_IN_SIZE_0  = 4;
  localparam int DEF_IN_SIZE_1  = 8;
  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_ACC_SIZE   = 32;

  // Partial sums travel sign/zero-extended to this width so one record type fits every configuration.
  localparam int PSUM_MAX_W = 64;

  function automatic int psum_width(input int in0, input int in1, input int lanes);
    return in0 + in1 + $clog2(lanes) + 1;
  endfunction

  typedef struct packed {
    logic [PSUM_MAX_W-1:0] psum;
    logic                  last;
    logic                  sgn;
    logic                  valid;
  } s2_t;

endpackage

// File: rtl/dot_sum_tree.sv
// Combinational lane multiply and adder tree; operands are sign- or zero-extended to PSUM first,
// so truncating the products and the sum to PSUM bits stays exact in both modes.
module dot_sum_tree
  import dot_acc_pkg::*;
#(
  parameter int IN_SIZE_0  = DEF_IN_SIZE_0,
  parameter int IN_SIZE_1  = DEF_IN_SIZE_1,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int PSUM       = psum_width(DEF_IN_SIZE_0, DEF_IN_SIZE_1, DEF_ARRAY_SIZE)
) (
  input  logic                 sgn_i,
  input  logic [IN_SIZE_0-1:0] a_i [0:ARRAY_SIZE-1],
  input  logic [IN_SIZE_1-1:0] b_i [0:ARRAY_SIZE-1],
  output logic [PSUM-1:0]      sum_o
);

  logic [PSUM-1:0] ea;
  logic [PSUM-1:0] eb;

  always_comb begin
    sum_o = '0;
    ea    = '0;
    eb    = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      ea    = {{(PSUM-IN_SIZE_0){sgn_i & a_i[i][IN_SIZE_0-1]}}, a_i[i]};
      eb    = {{(PSUM-IN_SIZE_1){sgn_i & b_i[i][IN_SIZE_1-1]}}, b_i[i]};
      sum_o = sum_o + ea * eb;
    end
  end

endmodule

// File: rtl/dot_acc_engine.sv
// Streaming three-stage dot-product accumulator: S1 input registers, S2 beat sum, S3 accumulate/output.
// Define DOT_ACC_SAT_EN for a saturating accumulator with a sticky per-vector out_ovf_o.
module dot_acc_engine
  import dot_acc_pkg::*;
#(
  parameter int IN_SIZE_0  = DEF_IN_SIZE_0,
  parameter int IN_SIZE_1  = DEF_IN_SIZE_1,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int ACC_SIZE   = DEF_ACC_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_last_i,
  input  logic                 in_signed_i,
  input  logic [IN_SIZE_0-1:0] in_0_i [0:ARRAY_SIZE-1],
  input  logic [IN_SIZE_1-1:0] in_1_i [0:ARRAY_SIZE-1],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_SIZE-1:0]  out_data_o,
  output logic                 out_ovf_o
);

  localparam int PSUM = psum_width(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE);

  // Handshakes: a beat moves on in_valid_i && in_ready_o, a result on out_valid_o && out_ready_i.
  // The whole pipe advances together and only stalls while a result waits for its consumer.
  logic adv;

  logic [IN_SIZE_0-1:0] s1_a_q [0:ARRAY_SIZE-1];
  logic [IN_SIZE_1-1:0] s1_b_q [0:ARRAY_SIZE-1];
  logic                 s1_last_q, s1_sgn_q, s1_valid_q;
  logic [PSUM-1:0]      psum;
  s2_t                  s2_d, s2_q;

  logic [ACC_SIZE-1:0]  acc_q, acc_d, base;
  logic                 first_q;
  logic                 out_valid_q;
  logic [ACC_SIZE-1:0]  out_data_q;
  logic                 ovf_d;

  assign adv         = !(out_valid_q && !out_ready_i);
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        s1_a_q[i] <= '0;
        s1_b_q[i] <= '0;
      end
      s1_last_q  <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_a_q     <= in_0_i;
      s1_b_q     <= in_1_i;
      s1_last_q  <= in_last_i;
      s1_sgn_q   <= in_signed_i;
      s1_valid_q <= in_valid_i;
    end
  end

  dot_sum_tree #(
    .IN_SIZE_0 (IN_SIZE_0),
    .IN_SIZE_1 (IN_SIZE_1),
    .ARRAY_SIZE(ARRAY_SIZE),
    .PSUM      (PSUM)
  ) u_sum_tree (
    .sgn_i(s1_sgn_q),
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .sum_o(psum)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.psum  = {{(PSUM_MAX_W-PSUM){s1_sgn_q & psum[PSUM-1]}}, psum};
    s2_d.last  = s1_last_q;
    s2_d.sgn   = s1_sgn_q;
    s2_d.valid = s1_valid_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    s2_q <= '0;
    else if (adv) s2_q <= s2_d;
  end

  assign base = first_q ? '0 : acc_q;

`ifdef DOT_ACC_SAT_EN
  localparam int AW = ACC_SIZE + 2;

  logic [AW-1:0] base_x, sum_x;
  logic          clamp, ovf_q, out_ovf_q;

  // Two guard bits hold the exact sum; it fits the signed range iff its top three bits agree.
  always_comb begin
    base_x = s2_q.sgn ? {{2{base[ACC_SIZE-1]}}, base} : {2'b00, base};
    sum_x  = base_x + s2_q.psum[AW-1:0];
    acc_d  = sum_x[ACC_SIZE-1:0];
    clamp  = 1'b0;
    if (s2_q.sgn) begin
      if (!((&sum_x[AW-1:ACC_SIZE-1]) || !(|sum_x[AW-1:ACC_SIZE-1]))) begin
        clamp = 1'b1;
        acc_d = sum_x[AW-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
      end
    end else if (|sum_x[AW-1:ACC_SIZE]) begin
      clamp = 1'b1;
      acc_d = '1;
    end
    ovf_d = (!first_q && ovf_q) || clamp;
  end

  assign out_ovf_o = out_ovf_q;
`else
  always_comb begin
    acc_d = base + s2_q.psum[ACC_SIZE-1:0];
    ovf_d = 1'b0;
  end

  assign out_ovf_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef DOT_ACC_SAT_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
      if (adv && s2_q.valid) begin
        if (s2_q.last) begin
          out_data_q  <= acc_d;
          out_valid_q <= 1'b1;
          first_q     <= 1'b1;
          acc_q       <= '0;
`ifdef DOT_ACC_SAT_EN
          out_ovf_q   <= ovf_d;
          ovf_q       <= 1'b0;
`endif
        end else begin
          acc_q   <= acc_d;
          first_q <= 1'b0;
`ifdef DOT_ACC_SAT_EN
          ovf_q   <= ovf_d;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_acc_engine.sv
// Bench for dot_acc_engine: a 32-bit and a 16-bit accumulator instance share one stimulus stream;
// a negedge monitor pops the expected queue whenever a result is consumed.
module tb_dot_acc_engine;

  localparam int N = 8;
`ifdef DOT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, in_signed, out_ready;
  logic [3:0] in0 [0:N-1];
  logic [7:0] in1 [0:N-1];

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [15:0] out_data_b;

  always #5 clk = ~clk;

  dot_acc_engine #(.IN_SIZE_0(4), .IN_SIZE_1(8), .ARRAY_SIZE(N), .ACC_SIZE(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .in_last_i(in_last), .in_signed_i(in_signed), .in_0_i(in0), .in_1_i(in1),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a), .out_ovf_o(out_ovf_a)
  );

  dot_acc_engine #(.IN_SIZE_0(4), .IN_SIZE_1(8), .ARRAY_SIZE(N), .ACC_SIZE(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_last_i(in_last), .in_signed_i(in_signed), .in_0_i(in0), .in_1_i(in1),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b), .out_ovf_o(out_ovf_b)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  // Entry layout: {ovf32, data32, ovf16, data16}.
  logic [49:0] exp_q[$];
  logic [49:0] mon_e;

  longint acc32 = 0, acc16 = 0;
  bit     first = 1'b1, ovf32 = 1'b0, ovf16 = 1'b0;

  typedef struct {
    bit          sgn;
    logic [3:0]  a;
    logic [7:0]  b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint beat_psum(input bit sgn);
    longint p = 0;
    for (int i = 0; i < N; i++) begin
      if (sgn) p += longint'($signed(in0[i])) * longint'($signed(in1[i]));
      else     p += longint'(in0[i]) * longint'(in1[i]);
    end
    return p;
  endfunction

  function automatic void acc_step(input int w, input longint acc, input bit frst, input bit ovf,
                                   input longint p, input bit sgn, output longint acc_o, output bit ovf_o);
    longint m, base, s;
    bit clamp = 1'b0;
    m    = longint'(1) << w;
    base = frst ? 0 : acc;
    if (SAT && sgn) begin
      if (base >= m / 2) base -= m;
      s = base + p;
      if (s > m / 2 - 1)      begin s = m / 2 - 1; clamp = 1'b1; end
      else if (s < -(m / 2))  begin s = -(m / 2);  clamp = 1'b1; end
    end else begin
      s = base + p;
      if (SAT && s > m - 1) begin s = m - 1; clamp = 1'b1; end
    end
    acc_o = ((s % m) + m) % m;
    ovf_o = (!frst && ovf) || clamp;
  endfunction

  task automatic set_uniform(input logic [3:0] a, input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      in0[i] = a;
      in1[i] = b;
    end
  endtask

  task automatic send(input bit sgn, input bit last, input bit use_exp, input logic [49:0] exp_c);
    bit ok = 1'b0;
    int n = 0;
    longint p, a32, a16;
    bit o32, o16;
    in_valid  = 1'b1;
    in_signed = sgn;
    in_last   = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      check("send_accept_timeout", 64'(ok), 64'd1);
      return;
    end
    p = beat_psum(sgn);
    acc_step(32, acc32, first, ovf32, p, sgn, a32, o32);
    acc_step(16, acc16, first, ovf16, p, sgn, a16, o16);
    if (last) begin
      exp_q.push_back(use_exp ? exp_c : {o32, a32[31:0], o16, a16[15:0]});
      first = 1'b1; acc32 = 0; acc16 = 0; ovf32 = 1'b0; ovf16 = 1'b0;
    end else begin
      first = 1'b0; acc32 = a32; acc16 = a16; ovf32 = o32; ovf16 = o16;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", out_data_a);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_acc32", 64'({out_ovf_a, out_data_a}), 64'(mon_e[49:17]));
        check("result_acc16", 64'({out_valid_b, out_ovf_b, out_data_b}), 64'({1'b1, mon_e[16:0]}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int p0, n;
    bit stall_ok, stop;
    int beats;
    logic [49:0] e;

    tbl[0] = '{0, 4'hF, 8'hFF, 32'd30600};
    tbl[1] = '{1, 4'h8, 8'h80, 32'd8192};
    tbl[2] = '{1, 4'hF, 8'h01, 32'hFFFFFFF8};
    tbl[3] = '{0, 4'h0, 8'hAB, 32'd0};
    tbl[4] = '{1, 4'h7, 8'h7F, 32'd7112};
    tbl[5] = '{1, 4'h8, 8'h7F, 32'hFFFFE040};
    tbl[6] = '{0, 4'h1, 8'h01, 32'd8};
    tbl[7] = '{1, 4'h7, 8'h80, 32'hFFFFE400};
    tbl[8] = '{0, 4'h8, 8'h80, 32'd8192};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
    set_uniform(4'h0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    check("reset_out_data", 64'({out_data_a, out_data_b}), 64'd0);
    check("reset_out_ovf", 64'({out_ovf_a, out_ovf_b}), 64'd0);
    check("reset_in_ready", 64'({in_ready_a, in_ready_b}), 64'd3);
    @(posedge clk); #1;

    // Latency: result visible after the third edge counting the accepting edge.
    out_ready = 1'b1;
    set_uniform(4'hF, 8'hFF);
    send(0, 1, 1, {1'b0, 32'd30600, 1'b0, 16'd30600});
    @(negedge clk);
    @(negedge clk);
    check("latency_not_early", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    check("latency_valid", 64'(out_valid_a), 64'd1);
    drain("drain_latency");

    for (int i = 0; i < 9; i++) begin
      set_uniform(tbl[i].a, tbl[i].b);
      e = {1'b0, tbl[i].exp, 1'b0, tbl[i].exp[15:0]};
      send(tbl[i].sgn, 1, 1, e);
    end
    drain("drain_table");

    p0 = pulses;
    for (int k = 1; k <= 4; k++) begin
      set_uniform(4'h1, 8'(k));
      send(0, k == 4, 1, {1'b0, 32'd80, 1'b0, 16'd80});
    end
    drain("drain_vec4");
    check("vec4_single_pulse", 64'(pulses - p0), 64'd1);

    p0 = pulses;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          set_uniform(4'(i + 1), 8'(10 * (i + 1)));
          send(0, 1, 0, '0);
        end
      end
      begin
        n = 0;
        while (!out_valid_a && n < 50) begin
          @(negedge clk);
          n++;
        end
        stall_ok = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (in_ready_a || !out_valid_a) stall_ok = 1'b0;
        end
        check("stall_in_ready_low", 64'(stall_ok), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_result_count", 64'(pulses - p0), 64'd4);

    set_uniform(4'hF, 8'hFF);
    send(0, 0, 0, '0);
    send(0, 0, 0, '0);
    send(0, 1, 1, {1'b0, 32'd91800, SAT, SAT ? 16'hFFFF : 16'd26264});
    drain("drain_wrap");

    out_ready = 1'b0;
    set_uniform(4'h3, 8'h03);
    send(0, 1, 0, '0);
    set_uniform(4'hF, 8'hFF);
    send(0, 0, 0, '0);
    n = 0;
    while (!out_valid_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    check("async_reset_data", 64'({out_data_a, out_data_b}), 64'd0);
    check("async_reset_ovf", 64'({out_ovf_a, out_ovf_b}), 64'd0);
    exp_q.delete();
    first = 1'b1; acc32 = 0; acc16 = 0; ovf32 = 1'b0; ovf16 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(0, 1, 1, {1'b0, 32'd30600, 1'b0, 16'd30600});
    drain("drain_after_reset");

    stop = 1'b0;
    fork
      begin
        while (!stop) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int v = 0; v < 8; v++) begin
          beats = $urandom_range(1, 4);
          for (int b = 0; b < beats; b++) begin
            for (int i = 0; i < N; i++) begin
              in0[i] = 4'($urandom_range(0, 15));
              in1[i] = 8'($urandom_range(0, 255));
            end
            send(1'($urandom_range(0, 1)), b == beats - 1, 0, '0);
          end
        end
        stop = 1'b1;
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
